// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed run-up, then timed de-integrate against
// the reference until the comparator trips or the timeout is reached.
module dual_slope_ctrl #(
    parameter int T_AZ  = 1000,
    parameter int T_INT = 10000,
    parameter int T_MAX = 20000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cmp_i,
    output logic        sw_az_o,
    output logic        sw_vin_o,
    output logic        sw_vref_o,
    output logic [15:0] result_o,
    output logic        valid_o,
    output logic        overrange_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AZ,
        S_INT,
        S_DEINT,
        S_DONE
    } state_t;

    localparam logic [15:0] AZ_LAST  = 16'(T_AZ - 1);
    localparam logic [15:0] INT_LAST = 16'(T_INT - 1);
    localparam logic [15:0] MAX_LAST = 16'(T_MAX - 1);
    localparam logic [15:0] MAX_VAL  = 16'(T_MAX);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] result_reg, result_next;
    logic        overrange_reg, overrange_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            result_reg    <= '0;
            overrange_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            result_reg    <= result_next;
            overrange_reg <= overrange_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        result_next    = result_reg;
        overrange_next = overrange_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_AZ;
                    cnt_next   = '0;
                end
            end
            S_AZ: begin
                if (cnt_reg == AZ_LAST) begin
                    state_next = S_INT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_INT: begin
                if (cnt_reg == INT_LAST) begin
                    state_next = S_DEINT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_DEINT: begin
                // A comparator trip wins over the timeout on the final count.
                if (!cmp_i) begin
                    result_next    = cnt_reg;
                    overrange_next = 1'b0;
                    state_next     = S_DONE;
                    cnt_next       = '0;
                end else if (cnt_reg == MAX_LAST) begin
                    result_next    = MAX_VAL;
                    overrange_next = 1'b1;
                    state_next     = S_DONE;
                    cnt_next       = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Switches are decoded from the registered state only, so they are mutually exclusive.
    assign sw_az_o     = (state_reg == S_AZ);
    assign sw_vin_o    = (state_reg == S_INT);
    assign sw_vref_o   = (state_reg == S_DEINT);
    assign valid_o     = (state_reg == S_DONE);
    assign busy_o      = (state_reg != S_IDLE);
    assign result_o    = result_reg;
    assign overrange_o = overrange_reg;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with a queue-based scoreboard checked on every valid_o.
module tb_dual_slope_ctrl;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        cmp_i;
    logic        sw_az_o;
    logic        sw_vin_o;
    logic        sw_vref_o;
    logic [15:0] result_o;
    logic        valid_o;
    logic        overrange_o;
    logic        busy_o;

    dual_slope_ctrl #(
        .T_AZ (4),
        .T_INT(8),
        .T_MAX(20)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cmp_i      (cmp_i),
        .sw_az_o    (sw_az_o),
        .sw_vin_o   (sw_vin_o),
        .sw_vref_o  (sw_vref_o),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .overrange_o(overrange_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        int az;
        int vin;
        int vref;
        int res;
        int ovr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   fall_cycle = 6;
    int   deint_n = 0;
    int   az_n = 0, vin_n = 0, vref_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: stays high until the fall_cycle-th DEINT cycle (0 means always low).
    always @(negedge clk) begin
        if (sw_vref_o) begin
            deint_n = deint_n + 1;
            cmp_i   = (deint_n < fall_cycle);
        end else begin
            deint_n = 0;
            cmp_i   = (fall_cycle != 0);
        end
    end

    // Monitor: measure switch phase lengths and compare against the scoreboard on valid_o.
    always @(negedge clk) begin
        if (rst_i) begin
            az_n = 0; vin_n = 0; vref_n = 0;
        end else begin
            total = total + 1;
            if ($countones({sw_az_o, sw_vin_o, sw_vref_o}) > 1) begin
                bad = bad + 1;
                $display("FAIL onehot: switches=%b required at most one high", {sw_az_o, sw_vin_o, sw_vref_o});
            end
            if (!busy_o) begin
                az_n = 0; vin_n = 0; vref_n = 0;
            end else begin
                if (sw_az_o)   az_n   = az_n + 1;
                if (sw_vin_o)  vin_n  = vin_n + 1;
                if (sw_vref_o) vref_n = vref_n + 1;
            end
            if (valid_o) begin
                total = total + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_valid: result=%0d ovr=%0d required no valid", result_o, overrange_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (az_n != e.az || vin_n != e.vin || vref_n != e.vref ||
                        int'(result_o) != e.res || int'(overrange_o) != e.ovr) begin
                        bad = bad + 1;
                        $display("FAIL conversion: az=%0d vin=%0d vref=%0d res=%0d ovr=%0d required az=%0d vin=%0d vref=%0d res=%0d ovr=%0d",
                                 az_n, vin_n, vref_n, result_o, overrange_o, e.az, e.vin, e.vref, e.res, e.ovr);
                    end else begin
                        $display("conversion ok: az=%0d vin=%0d vref=%0d res=%0d ovr=%0d", az_n, vin_n, vref_n, result_o, overrange_o);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int az, input int vin, input int vref, input int res, input int ovr);
        exp_t e;
        e.az = az; e.vin = vin; e.vref = vref; e.res = res; e.ovr = ovr;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid_o) return;
        end
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s_timeout: got no valid_o required valid_o within 200 cycles", name);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_sw_az", int'(sw_az_o), 0);
        chk("rst_sw_vin", int'(sw_vin_o), 0);
        chk("rst_sw_vref", int'(sw_vref_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_result", int'(result_o), 0);
        chk("rst_ovr", int'(overrange_o), 0);

        // Normal conversion: comparator trips on the 6th DEINT cycle.
        fall_cycle = 6;
        push_exp(4, 8, 6, 5, 0);
        pulse_start();
        wait_valid("normal");
        repeat (3) @(negedge clk);
        chk("hold_result", int'(result_o), 5);

        // Timeout: comparator never trips.
        fall_cycle = 10000;
        push_exp(4, 8, 20, 20, 1);
        pulse_start();
        wait_valid("timeout");
        repeat (2) @(negedge clk);
        chk("hold_ovr", int'(overrange_o), 1);

        // Comparator low from the first DEINT cycle.
        fall_cycle = 0;
        push_exp(4, 8, 1, 0, 0);
        pulse_start();
        wait_valid("zero");
        repeat (2) @(negedge clk);

        // start_i held high: back-to-back conversions with extra toggles mid-conversion.
        fall_cycle = 3;
        push_exp(4, 8, 3, 2, 0);
        push_exp(4, 8, 3, 2, 0);
        @(negedge clk);
        start_i = 1'b1;
        wait_valid("b2b_first");
        @(negedge clk);
        chk("gap_idle", int'(busy_o), 0);
        @(negedge clk);
        chk("gap_busy", int'(busy_o), 1);
        chk("gap_az", int'(sw_az_o), 1);
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        wait_valid("b2b_second");
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b_end_idle", int'(busy_o), 0);
        @(negedge clk);
        chk("b2b_no_third", int'(busy_o), 0);

        // Reset on the 3rd INT cycle aborts the conversion without a valid pulse.
        fall_cycle = 6;
        pulse_start();
        begin
            int vin_seen;
            vin_seen = 0;
            for (int i = 0; i < 100 && vin_seen < 3; i++) begin
                @(negedge clk);
                if (sw_vin_o) vin_seen = vin_seen + 1;
            end
            chk("abort_reached_int", vin_seen, 3);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_sw_az", int'(sw_az_o), 0);
        chk("abort_sw_vin", int'(sw_vin_o), 0);
        chk("abort_sw_vref", int'(sw_vref_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_result", int'(result_o), 0);
        chk("abort_valid", int'(valid_o), 0);
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", int'(busy_o), 0);

        push_exp(4, 8, 6, 5, 0);
        pulse_start();
        wait_valid("after_abort");
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
